// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry first-word-fall-through FIFO that
// carries PC, instruction and predictor metadata from fetch to decode.
// Flush discards every entry in one cycle. When the queue is empty the
// outputs present a NOP with valid low.
module if_id_queue #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int META_W = 1,
  parameter int DEPTH  = 4,
  parameter logic [ILEN-1:0] NOP_INSN = ILEN'(32'h00000013)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [ILEN-1:0]            i_instr,
  input  logic [META_W-1:0]          i_meta,
  output logic                       o_insn_vld,
  input  logic                       i_ready,
  output logic [XLEN-1:0]            o_pc,
  output logic [ILEN-1:0]            o_instr,
  output logic [META_W-1:0]          o_meta,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]   pcMem_q    [DEPTH];
  logic [ILEN-1:0]   instrMem_q [DEPTH];
  logic [META_W-1:0] metaMem_q  [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status flags come from the registered count only, so ready/valid have no
  // combinational path from the handshake inputs.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = i_valid & ~full & ~i_flush;
    pop   = ~empty & i_ready & ~i_flush;
  end

  // Next-state for pointers and occupancy; flush clears everything at once.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers; reset outranks flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is left unreset; the empty muxing keeps it from the outputs.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) begin
      pcMem_q[wrPtr_q]    <= i_pc;
      instrMem_q[wrPtr_q] <= i_instr;
      metaMem_q[wrPtr_q]  <= i_meta;
    end
  end

  // Head entry falls through to decode, or a NOP bubble when nothing is queued.
  always_comb begin
    o_ready    = ~full;
    o_insn_vld = ~empty;
    o_full     = full;
    o_empty    = empty;
    o_count    = count_q;
    o_pc       = '0;
    o_instr    = NOP_INSN;
    o_meta     = '0;
    if (!empty) begin
      o_pc    = pcMem_q[rdPtr_q];
      o_instr = instrMem_q[rdPtr_q];
      o_meta  = metaMem_q[rdPtr_q];
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised IF/ID decoupling queue. It replaces the single-entry IF/ID register with a DEPTH-entry FIFO and valid/ready handshakes on both sides. It carries PC, instruction and predictor metadata from fetch to decode, and absorbs decode stalls without stalling fetch until the queue is full. On a redirect, flush discards all entries in one cycle; when the queue is empty, the block presents a NOP (ADDI x0,x0,0) with valid low.

Parameters:
XLEN, 32, width of PC field
ILEN, 32, width of instruction field
META_W, 1, width of predictor metadata (bit 0 = pred_taken)
DEPTH, 4, number of entries; power of two, >= 2
NOP_INSN, 32'h00000013, instruction driven on o_instr when empty

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_flush  input  1  discard all entries (branch/jump redirect)
i_valid  input  1  IF presents an entry
o_ready  output  1  queue can accept (not full)
i_pc  input  XLEN  fetch PC
i_instr  input  ILEN  fetched instruction
i_meta  input  META_W  predictor metadata from IF
o_insn_vld  output  1  head entry valid to ID
i_ready  input  1  ID accepts head entry (inverse of ID stall)
o_pc  output  XLEN  head PC
o_instr  output  ILEN  head instruction
o_meta  output  META_W  head metadata
o_count  output  $clog2(DEPTH+1)  occupied entries
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0

Behaviour:
- State: storage array [DEPTH] of {pc, instr, meta}; wr_ptr and rd_ptr, each $clog2(DEPTH) bits; count register.
- Pointers wrap modulo DEPTH naturally (power-of-two depth). Count is explicit, with no extra pointer bit.
- push = i_valid & o_ready & ~i_flush. On push, write the entry at wr_ptr and increment wr_ptr.
- pop = o_insn_vld & i_ready & ~i_flush. On pop, increment rd_ptr.
- Count update: push only -> +1; pop only -> -1; both or neither -> unchanged.
- o_ready = ~o_full. It depends on registered state only, with no combinational path from i_ready or i_valid.
- o_insn_vld = ~o_empty.
- When not empty: o_pc, o_instr and o_meta = storage[rd_ptr], first-word-fall-through, driven combinationally from registered state only.
- When empty: o_pc = 0, o_instr = NOP_INSN, o_meta = 0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (1 cycle). There is no same-cycle bypass from IF to ID.
- Full: o_ready = 0, so no push occurs. A pop while full frees one slot; o_ready rises the following cycle.
- Empty: a pop is impossible because o_insn_vld = 0. A push while empty makes count = 1 next cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur; count is unchanged and the pointers both advance.
- Flush (priority over push and pop): at the next edge wr_ptr = rd_ptr = 0 and count = 0. The entry on i_* in the flush cycle is dropped, and no pop is reported to ID. Storage contents are don't-care.
- Flush while the queue is empty has no effect beyond resetting the pointers.
- Reset (priority over flush): synchronous. On the first rising edge with i_reset = 1, pointers and count = 0.
- Reset values, from the cycle after that edge: o_insn_vld = 0, o_ready = 1, o_empty = 1, o_full = 0, o_count = 0, o_pc = 0, o_instr = NOP_INSN, o_meta = 0.
- Storage is not reset.
- Reset asserted mid-operation discards all entries exactly as flush does.
- No X propagation: the outputs never expose unwritten storage, because the empty muxing is driven by count.

Test Plan:
- Reset/idle: assert i_reset for 2 cycles with i_valid = 1 -> o_insn_vld = 0, o_instr = 32'h00000013, o_pc = 0, o_count = 0, o_ready = 1. Nothing is captured during reset.
- Fill under stall: i_ready = 0; push pc 0x0, 0x4, 0x8, 0xC with instrs 0xA0..0xA3 -> o_count 1..4. After the 4th push, o_full = 1 and o_ready = 0. A 5th pc 0x10 held on i_valid is not accepted. o_pc stays 0x0 throughout.
- Drain: from full, set i_ready = 1 and i_valid = 0 -> o_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, then o_insn_vld = 0 and o_instr = NOP. o_ready returns to 1 the cycle after the first pop.
- Streaming plus wrap: i_valid = i_ready = 1 continuously for 3*DEPTH cycles, with pc incrementing by 4 -> one-cycle latency and in-order o_pc with no gaps. o_count holds at 1 while pointers wrap; meta bit patterns 1,0,1,... are preserved.
- Flush with concurrent traffic: count = 3, then assert i_flush with i_valid = 1 (pc 0x40) and i_ready = 1 -> next cycle o_count = 0 and o_insn_vld = 0; pc 0x40 is absent. A push of pc 0x80 on the following cycle appears as the next o_pc.
- Reset mid-operation: count = 2, assert i_reset together with i_flush and i_valid -> reset values next cycle. After deassertion, a push of pc 0x100 appears at o_pc with o_count = 1.
